instr_mem_axi_slave: RTL and testbench

AXI4-style read-only instruction memory responder serving the fetch-side AR/R read master. Accepts one read-address handshake at a time, then streams `arlen+1` 32-bit beats on the R channel with full `rready` backpressure and an `rlast` marker. A separate synchronous write port preloads or patches the memory array.

---
 rtl/instr_mem_axi_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_instr_mem_axi_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_axi_slave.sv
// Read-only AXI4-style instruction memory responder.
// Accepts one AR handshake at a time and streams arlen+1 registered beats on R.
// A separate synchronous write port preloads or patches the word array.
module instr_mem_axi_slave #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_LOAD = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;       // address of the beat currently presented
    logic [7:0]  cnt_q, cnt_d;         // beats remaining after the presented one
    logic [3:0]  lat_q, lat_d;
    logic        err_q, err_d;         // whole burst answers SLVERR
    logic        fixed_q, fixed_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] ar_aligned_s;
    logic        ar_err_s;
    logic [31:0] next_addr_s;
    logic [31:0] load_addr_s;
    logic        load_err_s;
    logic [31:0] load_word_s;
    logic [31:0] beat_data_s;
    logic [1:0]  beat_resp_s;
    logic [31:0] wr_word_s;
    logic        wr_ok_s;

    assign ar_aligned_s = araddr & ~32'h0000_0003;
    assign ar_err_s     = (arsize != 3'd2) || arburst[1];
    assign next_addr_s  = fixed_q ? addr_q : (addr_q + 32'd4);
    assign wr_word_s    = (wr_addr - ADDR_BASE) >> 2;
    assign wr_ok_s      = wr_en && (wr_addr >= ADDR_BASE) && (wr_word_s < 32'(DEPTH_WORDS));

    // Pick the address and error flag of the beat that would be loaded on this edge.
    always_comb begin
        load_addr_s = next_addr_s;
        load_err_s  = err_q;
        case (state_q)
            ST_IDLE: begin
                load_addr_s = ar_aligned_s;
                load_err_s  = ar_err_s;
            end
            ST_WAIT: begin
                load_addr_s = addr_q;
                load_err_s  = err_q;
            end
            ST_BURST: begin
                load_addr_s = next_addr_s;
                load_err_s  = err_q;
            end
            default: begin
                load_addr_s = addr_q;
                load_err_s  = err_q;
            end
        endcase
    end

    // Beat contents: SLVERR wins over the per-beat range check, which wins over data.
    always_comb begin
        load_word_s = (load_addr_s - ADDR_BASE) >> 2;
        beat_data_s = 32'd0;
        beat_resp_s = RESP_OKAY;
        if (load_err_s) begin
            beat_resp_s = RESP_SLVERR;
        end else if ((load_addr_s < ADDR_BASE) || (load_word_s >= 32'(DEPTH_WORDS))) begin
            beat_resp_s = RESP_DECERR;
        end else begin
            beat_data_s = mem_q[load_word_s[IDX_W-1:0]];
        end
    end

    // Next-state logic for the AR/WAIT/BURST sequencer and the registered R outputs.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        err_d   = err_q;
        fixed_d = fixed_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        case (state_q)
            ST_IDLE: begin
                if (arvalid && arready_q) begin
                    addr_d  = ar_aligned_s;
                    cnt_d   = arlen;
                    err_d   = ar_err_s;
                    fixed_d = (arburst == 2'b00);
                    if (READ_LATENCY == 0) begin
                        state_d  = ST_BURST;
                        lat_d    = 4'd0;
                        rvalid_d = 1'b1;
                        rdata_d  = beat_data_s;
                        rresp_d  = beat_resp_s;
                        rlast_d  = (arlen == 8'd0);
                    end else begin
                        state_d = ST_WAIT;
                        lat_d   = LAT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_q == 4'd0) begin
                    state_d  = ST_BURST;
                    rvalid_d = 1'b1;
                    rdata_d  = beat_data_s;
                    rresp_d  = beat_resp_s;
                    rlast_d  = (cnt_q == 8'd0);
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            ST_BURST: begin
                if (rvalid_q && rready) begin
                    if (cnt_q == 8'd0) begin
                        state_d  = ST_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = next_addr_s;
                        rdata_d = beat_data_s;
                        rresp_d = beat_resp_s;
                        rlast_d = (cnt_q == 8'd1);
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
            end
        endcase
        arready_d = (state_d == ST_IDLE);
    end

    // Sequencer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            cnt_q     <= 8'd0;
            lat_q     <= 4'd0;
            err_q     <= 1'b0;
            fixed_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            err_q     <= err_d;
            fixed_q   <= fixed_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // Preload/patch port; contents survive reset and beats read the pre-write value.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_word_s[IDX_W-1:0]] <= wr_data;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule

// File: tb/tb_instr_mem_axi_slave.sv
// Bench for instr_mem_axi_slave: a latency-0 instance runs a vector table and
// a reset-mid-burst sequence; a latency-3 instance runs the FIXED/latency case.
module tb_instr_mem_axi_slave;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] SLV = 2'b10;
    localparam logic [1:0] DEC = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]        arvalid_w;
    logic [1:0]        arready_w;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        rvalid_w;
    logic              rready;
    logic [1:0][31:0]  rdata_w;
    logic [1:0][1:0]   rresp_w;
    logic [1:0]        rlast_w;
    logic              wr_en;
    logic [31:0]       wr_addr;
    logic [31:0]       wr_data;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [6:0]       rr;     // rready per presented cycle, bit 0 first; 1 afterwards
        logic [3:0][31:0] d;      // expected rdata per beat
        logic [3:0][1:0]  r;      // expected rresp per beat
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t sb[$];
    vec_t  vecs[8];

    always #5 clk = ~clk;

    instr_mem_axi_slave #(.READ_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .arvalid(arvalid_w[0]), .arready(arready_w[0]),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid_w[0]), .rready(rready), .rdata(rdata_w[0]),
        .rresp(rresp_w[0]), .rlast(rlast_w[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    instr_mem_axi_slave #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .arvalid(arvalid_w[1]), .arready(arready_w[1]),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid_w[1]), .rready(rready), .rdata(rdata_w[1]),
        .rresp(rresp_w[1]), .rlast(rlast_w[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                input logic [1:0] b, input logic [6:0] rr,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] r0, input logic [1:0] r1,
                                input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v.addr = a; v.len = l; v.size = s; v.burst = b; v.rr = rr;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
        return v;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Runs one burst on instance sel; called and returning at a negedge.
    task automatic do_burst(input int sel, input vec_t v, input int lat);
        int k;
        int pi;
        int guard;
        logic hold;
        logic [31:0] hd;
        logic [1:0] hr;
        logic hl;
        beat_t e;
        for (int i = 0; i <= int'(v.len); i++) begin
            e.data = v.d[i]; e.resp = v.r[i]; e.last = (i == int'(v.len));
            sb.push_back(e);
        end
        guard = 0;
        while (!arready_w[sel] && guard < 20) begin
            @(negedge clk); guard++;
        end
        chk("arready_before_ar", {31'd0, arready_w[sel]}, 32'd1);
        araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
        arvalid_w[sel] = 1'b1;
        rready = 1'b0;
        @(negedge clk);
        arvalid_w = 2'b00;
        k = 1;
        while (!rvalid_w[sel] && k < 40) begin
            chk("arready_low_wait", {31'd0, arready_w[sel]}, 32'd0);
            @(negedge clk); k++;
        end
        chk("first_valid_latency", k, lat + 1);
        pi = 0; hold = 1'b0; guard = 0;
        hd = 32'd0; hr = 2'b00; hl = 1'b0;
        while (sb.size() > 0 && guard < 60) begin
            chk("rvalid_in_burst", {31'd0, rvalid_w[sel]}, 32'd1);
            chk("arready_low_burst", {31'd0, arready_w[sel]}, 32'd0);
            if (rvalid_w[sel]) begin
                if (hold) begin
                    chk("stall_rdata", rdata_w[sel], hd);
                    chk("stall_rresp", {30'd0, rresp_w[sel]}, {30'd0, hr});
                    chk("stall_rlast", {31'd0, rlast_w[sel]}, {31'd0, hl});
                end
                rready = (pi < 7) ? v.rr[pi] : 1'b1;
                pi++;
                if (rready) begin
                    e = sb.pop_front();
                    chk("beat_rdata", rdata_w[sel], e.data);
                    chk("beat_rresp", {30'd0, rresp_w[sel]}, {30'd0, e.resp});
                    chk("beat_rlast", {31'd0, rlast_w[sel]}, {31'd0, e.last});
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    hd = rdata_w[sel]; hr = rresp_w[sel]; hl = rlast_w[sel];
                end
            end else begin
                rready = 1'b0;
            end
            @(negedge clk); guard++;
        end
        chk("burst_beats_left", sb.size(), 32'd0);
        sb.delete();
        rready = 1'b0;
        chk("rvalid_after_last", {31'd0, rvalid_w[sel]}, 32'd0);
        chk("rlast_after_last", {31'd0, rlast_w[sel]}, 32'd0);
        chk("arready_after_last", {31'd0, arready_w[sel]}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; arvalid_w = 2'b00; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2;
        arburst = 2'b01; rready = 1'b0; wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;

        vecs[0] = mk(32'h0000_0000, 8'd0, 3'd2, 2'b01, 7'h7F,
                     32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, OK, OK, OK, OK);
        vecs[1] = mk(32'h0000_0010, 8'd3, 3'd2, 2'b01, 7'b1011001,
                     32'd1, 32'd2, 32'd3, 32'd4, OK, OK, OK, OK);
        vecs[2] = mk(32'h0000_0000, 8'd1, 3'd1, 2'b01, 7'h7F,
                     32'd0, 32'd0, 32'd0, 32'd0, SLV, SLV, OK, OK);
        vecs[3] = mk(32'h0000_0FFC, 8'd1, 3'd2, 2'b01, 7'h7F,
                     32'h1234_5678, 32'd0, 32'd0, 32'd0, OK, DEC, OK, OK);
        vecs[4] = mk(32'h0000_0013, 8'd1, 3'd2, 2'b00, 7'b0000101,
                     32'd1, 32'd1, 32'd0, 32'd0, OK, OK, OK, OK);
        vecs[5] = mk(32'h0000_0004, 8'd0, 3'd2, 2'b10, 7'h7F,
                     32'd0, 32'd0, 32'd0, 32'd0, SLV, OK, OK, OK);
        vecs[6] = mk(32'h0000_1000, 8'd0, 3'd2, 2'b01, 7'h7F,
                     32'd0, 32'd0, 32'd0, 32'd0, DEC, OK, OK, OK);
        vecs[7] = mk(32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 7'h7F,
                     32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, DEC, OK, OK, OK);

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_arready", {31'd0, arready_w[s]}, 32'd0);
            chk("reset_rvalid", {31'd0, rvalid_w[s]}, 32'd0);
            chk("reset_rlast", {31'd0, rlast_w[s]}, 32'd0);
            chk("reset_rdata", rdata_w[s], 32'd0);
            chk("reset_rresp", {30'd0, rresp_w[s]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_arready0", {31'd0, arready_w[0]}, 32'd1);
        chk("post_reset_arready3", {31'd0, arready_w[1]}, 32'd1);

        wr(32'h0000_0000, 32'hDEAD_BEEF);
        wr(32'h0000_0010, 32'd1);
        wr(32'h0000_0015, 32'd2);           // low address bits ignored
        wr(32'h0000_0018, 32'd3);
        wr(32'h0000_001C, 32'd4);
        wr(32'h0000_0FFC, 32'h1234_5678);
        wr(32'h0000_1000, 32'hBAD0_BAD0);   // out of range, dropped

        for (int i = 0; i < 8; i++) begin
            do_burst(0, vecs[i], 0);
        end

        // Reset abandons a burst during its second beat.
        araddr = 32'h0000_0010; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
        arvalid_w[0] = 1'b1;
        @(negedge clk);
        arvalid_w = 2'b00;
        chk("rst_mid_beat1", rdata_w[0], 32'd1);
        rready = 1'b1;
        @(negedge clk);
        chk("rst_mid_beat2", rdata_w[0], 32'd2);
        rst_n = 1'b0; rready = 1'b0;
        @(negedge clk);
        chk("rst_mid_rvalid", {31'd0, rvalid_w[0]}, 32'd0);
        chk("rst_mid_arready", {31'd0, arready_w[0]}, 32'd0);
        chk("rst_mid_rdata", rdata_w[0], 32'd0);
        chk("rst_mid_rlast", {31'd0, rlast_w[0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_arready", {31'd0, arready_w[0]}, 32'd1);
        chk("rst_release_rvalid", {31'd0, rvalid_w[0]}, 32'd0);
        do_burst(0, vecs[1], 0);

        // FIXED burst through the latency-3 instance.
        wr(32'h0000_0014, 32'h0000_00A5);
        do_burst(1, mk(32'h0000_0014, 8'd2, 3'd2, 2'b00, 7'h7F,
                       32'hA5, 32'hA5, 32'hA5, 32'd0, OK, OK, OK, OK), 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
